// File: rtl/fft_pkg.sv
// Shared definitions for the FFT-to-UART transmit framer:
// FSM state encoding, checksum width and frame geometry helpers.
package fft_pkg;

    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        WAIT,
        CSUM,
        DONE
    } state_e;

    // UART bytes per real or imaginary word
    function automatic int bpw(input int word_size, input int data_length);
        return word_size / data_length;
    endfunction

    // bytes in one complete frame, including the optional checksum byte
    function automatic int frame_len(input int fft_size, input int word_size,
                                     input int data_length, input bit csum_en);
        return fft_size * 2 * bpw(word_size, data_length) + (csum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/fft_uart_byte_shifter.sv
// {re, im} load/shift register with per-bin byte counter.
// Ports: i_clk, i_rst, i_load, i_shift, i_re, i_im -> o_byte, o_last.
module fft_uart_byte_shifter
    import fft_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic                   i_shift,
    input  logic [WORD_SIZE-1:0]   i_re,
    input  logic [WORD_SIZE-1:0]   i_im,
    output logic [DATA_LENGTH-1:0] o_byte,
    output logic                   o_last
);

    localparam int BPB   = 2 * bpw(WORD_SIZE, DATA_LENGTH);
    localparam int CNT_W = (BPB > 2) ? $clog2(BPB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPB - 1);

    logic [2*WORD_SIZE-1:0] sreg_q;
    logic [CNT_W-1:0]       cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (i_load) begin
            sreg_q <= {i_re, i_im};
            cnt_q  <= '0;
        end else if (i_shift) begin
            sreg_q <= sreg_q << DATA_LENGTH;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign o_byte = sreg_q[2*WORD_SIZE-1 -: DATA_LENGTH];
    assign o_last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fft_uart_framer.sv
// Walks the FFT result memory and streams each bin (re then im, MSB-first
// bytes) to UART_TX via its start/done handshake.
// Ports: i_clk, i_rst, i_start, i_re, i_im, i_tx_done ->
//        o_rd_addr, o_tx_start, o_tx_byte, o_busy, o_done.
// Optional: define FFT_UART_FRAMER_CHECKSUM_EN to append a mod-256
// byte sum after the last data byte.
module fft_uart_framer
    import fft_pkg::*;
#(
    parameter int FFT_SIZE    = 16,
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int ADDR_W      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic [ADDR_W-1:0]      o_rd_addr,
    input  logic [WORD_SIZE-1:0]   i_re,
    input  logic [WORD_SIZE-1:0]   i_im,
    output logic                   o_tx_start,
    output logic [DATA_LENGTH-1:0] o_tx_byte,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_SIZE - 1);

    state_e                 state_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic                   tx_start_q;
    logic [DATA_LENGTH-1:0] tx_byte_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_LENGTH-1:0] sh_byte;
    logic                   sh_last;
    logic                   sh_load;
    logic                   sh_shift;

`ifdef FFT_UART_FRAMER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum_q;
    // set once the checksum byte is in flight
    logic              csum_q;
`endif

    assign sh_load  = (state_q == LATCH);
    assign sh_shift = (state_q == WAIT) && i_tx_done;

    fft_uart_byte_shifter #(
        .WORD_SIZE  (WORD_SIZE),
        .DATA_LENGTH(DATA_LENGTH)
    ) u_shifter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (sh_load),
        .i_shift(sh_shift),
        .i_re   (i_re),
        .i_im   (i_im),
        .o_byte (sh_byte),
        .o_last (sh_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
            sum_q      <= '0;
            csum_q     <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                        sum_q     <= '0;
`endif
                    end
                end
                // memory read latency
                FETCH: state_q <= LATCH;
                LATCH: state_q <= SEND;
                SEND: begin
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= sh_byte;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                    sum_q      <= sum_q + CSUM_W'(sh_byte);
`endif
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (i_tx_done) begin
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                        if (csum_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else
`endif
                        if (!sh_last) begin
                            state_q <= SEND;
                        end else if (rd_addr_q != LAST_BIN) begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                            state_q   <= FETCH;
                        end else begin
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            done_q  <= 1'b1;
                            state_q <= DONE;
`endif
                        end
                    end
                end
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                CSUM: begin
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= DATA_LENGTH'(sum_q);
                    csum_q     <= 1'b1;
                    state_q    <= WAIT;
                end
`endif
                // o_done is high during this cycle, so a coincident
                // i_start is deliberately not accepted
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                    csum_q  <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rd_addr  = rd_addr_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: doc/fft_uart_framer.md
Name: fft_uart_framer

Overview:
- Transmit-side framer that carries FFT results to the host over UART; the counterpart of the command path, which receives bytes from the host.
- On a frame request it walks the FFT result memory (bins 0..FFT_SIZE-1) and serializes each complex bin, real part then imaginary part, into DATA_LENGTH-bit bytes.
- Each byte is handed to UART_TX through its start/done handshake.
- Sits in top between the FFT result buffer and UART_TX.

Parameters:
- FFT_SIZE, 16, number of bins per frame (power of two)
- WORD_SIZE, 16, bit width of each real/imag result word
- DATA_LENGTH, 8, UART byte width; WORD_SIZE must be an integer multiple of it
- ADDR_W, 4, result-memory address width, equal to log2(FFT_SIZE)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle frame request (FFT cycle done)
- o_rd_addr  out  ADDR_W  result-memory bin address
- i_re  in  WORD_SIZE  real word; valid one cycle after o_rd_addr
- i_im  in  WORD_SIZE  imag word; valid one cycle after o_rd_addr
- o_tx_start  out  1  one-cycle pulse to UART_TX i_start
- o_tx_byte  out  DATA_LENGTH  byte to UART_TX i_TX_byte; held stable until i_tx_done
- i_tx_done  in  1  UART_TX o_TX_done, one-cycle pulse
- o_busy  out  1  high while a frame is in progress
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done

Behaviour:
- Reset values (asynchronous): all outputs 0; state IDLE; all counters 0.
- Constants:
  - BPW = WORD_SIZE/DATA_LENGTH (2 at defaults)
  - bytes per bin = 2*BPW
  - frame length = FFT_SIZE*2*BPW (64 at defaults)
- Byte order per bin: re MSB-first, then im MSB-first. Bytes are sliced from a 2*WORD_SIZE shift register loaded with {re, im}; shift left by DATA_LENGTH per byte.
- State machine:
  - IDLE: on i_start, set bin counter 0, drive o_rd_addr=0, o_busy=1, go to FETCH.
  - FETCH: one wait cycle for memory latency, then go to LATCH.
  - LATCH: load the shift register from i_re/i_im, set byte counter 0, go to SEND.
  - SEND: pulse o_tx_start for one cycle with o_tx_byte = shift register MSBs, go to WAIT.
  - WAIT: on i_tx_done, shift the register and increment the byte counter.
    - If more bytes remain in the bin, go to SEND.
    - Else if more bins remain, increment o_rd_addr and go to FETCH.
    - Else go to DONE.
  - DONE: pulse o_done, clear o_busy, go to IDLE.
- Latency: i_start sampled at edge 0 produces the first o_tx_start at edge 3. After each i_tx_done, the next o_tx_start comes 1 cycle later within a bin, or 3 cycles later across bins.
- Boundary conditions:
  - i_start outside IDLE is ignored (no queuing).
  - i_tx_done outside WAIT is ignored.
  - The bin counter stops at FFT_SIZE-1; o_rd_addr never wraps mid-frame.
  - Asserting i_rst mid-frame aborts immediately: o_tx_start drops in the same cycle, and UART_TX is allowed to finish its current byte. After reset the framer is in IDLE.
  - i_start in the same cycle as o_done: not accepted, because the state is still DONE; it must be reissued.

Optional Feature:
- Macro: FFT_UART_FRAMER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every data byte when its o_tx_start pulses; the sum clears on i_start acceptance.
  - After the last data byte's i_tx_done, a CSUM state sends the sum as one extra byte with the same SEND/WAIT handshake, then goes to DONE.
  - Frame length becomes 65 at defaults.
- Undefined: no checksum logic exists; frame length is exactly FFT_SIZE*2*BPW.

Decomposition:
- Shared package fft_pkg holds:
  - FSM state encodings: IDLE, FETCH, LATCH, SEND, WAIT, CSUM, DONE
  - the BPW and frame-length calculation
  - checksum width constant CSUM_W=8
- One natural sub-module, fft_uart_byte_shifter: the {re, im} load/shift register plus byte counter, exposing the current byte and last_byte_in_bin.

Test Plan:
- Basic frame:
  - Stimulus: memory bin k holds re=16'h0100+k, im=16'hF000+k; pulse i_start; UART_TX model gives i_tx_done 200 cycles after each o_tx_start.
  - Required: 64 bytes; the first four are 01,00,F0,00; the last four are 01,0F,F0,0F; one o_done pulse; o_busy low afterwards.
- Handshake timing:
  - Stimulus: i_tx_done 1 cycle after each o_tx_start.
  - Required: o_tx_start spacing 2 cycles within a bin and 4 cycles across bins; o_tx_byte stable from each o_tx_start until its i_tx_done.
- Ignored events:
  - Stimulus: i_start pulsed at byte 10; spurious i_tx_done while in FETCH.
  - Required: byte count still 64; no byte skipped or repeated.
- Reset mid-frame:
  - Stimulus: assert i_rst during WAIT of byte 20.
  - Required: all outputs 0 asynchronously. A following i_start produces a full 64-byte frame beginning at bin 0.
- Checksum (FFT_UART_FRAMER_CHECKSUM_EN defined):
  - Stimulus: data from the basic-frame test.
  - Required: 65 bytes; the final byte equals the 8-bit sum of the 64 data bytes.
- Back-to-back frames:
  - Stimulus: i_start in the o_done cycle, then again 1 cycle later.
  - Required: the first request is ignored; the second starts a new frame at edge+3.
